updown_counter_param: RTL and testbench

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

---
 rtl/updown_counter_param.sv | 141 ++++++++++++++
 tb/tb_updown_counter_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with a free-running count-enable prescaler,
// wrap or saturate bound handling, and sticky overflow/underflow flags.
module updown_counter_param #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               STEP_W   = 4,
  parameter int               PRESCALE = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [1:0]        s_in,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [STEP_W-1:0] step_in,
  input  logic              sat_mode_in,
  input  logic              clr_flags_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc_out,
  output logic              ovf_out,
  output logic              unf_out,
  output logic              tick_out
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam int              PW        = 16;
  localparam logic [PW-1:0]   P_LAST    = PW'(PRESCALE - 1);
  localparam logic [WIDTH:0]  MAX_EXT   = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0]  MODULUS   = MAX_EXT + (WIDTH+1)'(1);
  localparam logic [32:0]     STEP_PEAK = (33'd1 << STEP_W) - 33'd1;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be 2..32");
  end
  if (STEP_W < 1 || STEP_W > WIDTH) begin : g_bad_step_w
    $error("updown_counter_param: STEP_W must be 1..WIDTH");
  end
  if (33'(MAX_VAL) < STEP_PEAK) begin : g_bad_max_val
    $error("updown_counter_param: MAX_VAL must be >= 2**STEP_W-1");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("updown_counter_param: PRESCALE must be 1..65535");
  end

  mode_e            mode;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_next;
  logic [WIDTH:0]   data_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   inc_wrap;
  logic [WIDTH:0]   dec_wrap;
  logic             over;
  logic             under;
  logic [WIDTH-1:0] next_data;
  logic             next_tc;
  logic             set_ovf;
  logic             set_unf;

  assign mode       = mode_e'(s_in);
  assign presc_next = (presc == P_LAST) ? '0 : presc + PW'(1);

  // All bound arithmetic is one bit wider than the counter so carries and
  // borrows are visible before the result is folded back into range.
  assign data_ext = {1'b0, data_out};
  assign step_ext = (WIDTH+1)'(step_in);
  assign sum      = data_ext + step_ext;
  assign inc_wrap = sum - MODULUS;
  assign dec_wrap = data_ext + MODULUS - step_ext;
  assign over     = sum > MAX_EXT;
  assign under    = step_ext > data_ext;

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_data = data_out;
    next_tc   = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    unique case (mode)
      MODE_LOAD: begin
        if ({1'b0, data_in} > MAX_EXT) begin
          next_data = MAX_VAL;
          next_tc   = 1'b1;
          set_ovf   = 1'b1;
        end else begin
          next_data = data_in;
        end
      end
      MODE_INC: begin
        if (tick_out) begin
          if (over) begin
            next_data = sat_mode_in ? MAX_VAL : inc_wrap[WIDTH-1:0];
            next_tc   = 1'b1;
            set_ovf   = 1'b1;
          end else begin
            next_data = sum[WIDTH-1:0];
          end
        end
      end
      MODE_DEC: begin
        if (tick_out) begin
          if (under) begin
            next_data = sat_mode_in ? '0 : dec_wrap[WIDTH-1:0];
            next_tc   = 1'b1;
            set_unf   = 1'b1;
          end else begin
            next_data = data_out - step_ext[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      presc    <= '0;
      tick_out <= 1'b0;
      data_out <= '0;
      tc_out   <= 1'b0;
      ovf_out  <= 1'b0;
      unf_out  <= 1'b0;
    end else begin
      presc    <= presc_next;
      tick_out <= (presc_next == P_LAST);
      data_out <= next_data;
      tc_out   <= next_tc;
      // A set event in the same cycle as a clear request wins.
      ovf_out  <= set_ovf | (ovf_out & ~clr_flags_in);
      unf_out  <= set_unf | (unf_out & ~clr_flags_in);
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: three counter configurations, directed vectors queued with
// hand-computed results and checked by an independent per-cycle monitor.
module tb_updown_counter_param;

  localparam logic [1:0] HOLD = 2'b00, INC = 2'b01, DEC = 2'b10, LD = 2'b11;

  typedef struct {
    int         due;
    int         sel;
    string      name;
    logic [7:0] data;
    logic       tc;
    logic       ovf;
    logic       unf;
    int         tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i  [3] = '{1'b1, 1'b1, 1'b1};
  logic [1:0] s_i    [3] = '{2'b00, 2'b00, 2'b00};
  logic [7:0] d_i    [3] = '{8'd0, 8'd0, 8'd0};
  logic [3:0] st_i   [3] = '{4'd0, 4'd0, 4'd0};
  logic       sat_i  [3] = '{1'b0, 1'b0, 1'b0};
  logic       clr_i  [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] data_o [3];
  logic       tc_o   [3];
  logic       ovf_o  [3];
  logic       unf_o  [3];
  logic       tick_o [3];

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(8), .STEP_W(4)) u_a (
    .clk_in(clk), .reset_in(rst_i[0]), .s_in(s_i[0]), .data_in(d_i[0]),
    .step_in(st_i[0]), .sat_mode_in(sat_i[0]), .clr_flags_in(clr_i[0]),
    .data_out(data_o[0]), .tc_out(tc_o[0]), .ovf_out(ovf_o[0]),
    .unf_out(unf_o[0]), .tick_out(tick_o[0]));

  updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd199), .STEP_W(4)) u_b (
    .clk_in(clk), .reset_in(rst_i[1]), .s_in(s_i[1]), .data_in(d_i[1]),
    .step_in(st_i[1]), .sat_mode_in(sat_i[1]), .clr_flags_in(clr_i[1]),
    .data_out(data_o[1]), .tc_out(tc_o[1]), .ovf_out(ovf_o[1]),
    .unf_out(unf_o[1]), .tick_out(tick_o[1]));

  updown_counter_param #(.WIDTH(8), .STEP_W(4), .PRESCALE(4)) u_c (
    .clk_in(clk), .reset_in(rst_i[2]), .s_in(s_i[2]), .data_in(d_i[2]),
    .step_in(st_i[2]), .sat_mode_in(sat_i[2]), .clr_flags_in(clr_i[2]),
    .data_out(data_o[2]), .tc_out(tc_o[2]), .ovf_out(ovf_o[2]),
    .unf_out(unf_o[2]), .tick_out(tick_o[2]));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of stimulus for instance sel and queues the result due
  // after the next rising edge. e_tick < 0 leaves tick_out unchecked.
  task automatic drive(input int sel, input logic rst, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] st,
                       input logic sat, input logic clr, input string name,
                       input logic [7:0] e_data, input logic e_tc,
                       input logic e_ovf, input logic e_unf, input int e_tick);
    exp_t e;
    @(posedge clk);
    #1;
    rst_i[sel] = rst;
    s_i[sel]   = s;
    d_i[sel]   = d;
    st_i[sel]  = st;
    sat_i[sel] = sat;
    clr_i[sel] = clr;
    e.due  = cyc + 1;
    e.sel  = sel;
    e.name = name;
    e.data = e_data;
    e.tc   = e_tc;
    e.ovf  = e_ovf;
    e.unf  = e_unf;
    e.tick = e_tick;
    q.push_back(e);
  endtask

  // Monitor: counts edges and retires every expectation that has come due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check({e.name, "_due"}, e.due, cyc);
        check({e.name, "_data"}, int'(data_o[e.sel]), int'(e.data));
        check({e.name, "_tc"},   int'(tc_o[e.sel]),   int'(e.tc));
        check({e.name, "_ovf"},  int'(ovf_o[e.sel]),  int'(e.ovf));
        check({e.name, "_unf"},  int'(unf_o[e.sel]),  int'(e.unf));
        if (e.tick >= 0) check({e.name, "_tick"}, int'(tick_o[e.sel]), e.tick);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Defaults: MAX 255, PRESCALE 1. Reset overrides an active INCREMENT.
    drive(0, 1, INC,  8'd55,  4'd3, 1, 1, "a_reset",   8'd0,   0, 0, 0, 0);
    drive(0, 0, LD,   8'd200, 4'd0, 0, 0, "a_ld200",   8'd200, 0, 0, 0, 1);
    drive(0, 0, LD,   8'd245, 4'd0, 0, 0, "a_ld245",   8'd245, 0, 0, 0, 1);
    drive(0, 0, LD,   8'd0,   4'd0, 0, 0, "a_ld0",     8'd0,   0, 0, 0, 1);
    drive(0, 0, LD,   8'd255, 4'd0, 0, 0, "a_ld255",   8'd255, 0, 0, 0, 1);
    // Wrap around the top and bottom bounds.
    drive(0, 0, LD,   8'd254, 4'd0, 0, 0, "a_ld254",   8'd254, 0, 0, 0, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_inc255",  8'd255, 0, 0, 0, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_incwrap", 8'd0,   1, 1, 0, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_inc1",    8'd1,   0, 1, 0, 1);
    drive(0, 0, DEC,  8'd0,   4'd1, 0, 0, "a_dec0",    8'd0,   0, 1, 0, 1);
    drive(0, 0, DEC,  8'd0,   4'd1, 0, 0, "a_decwrap", 8'd255, 1, 1, 1, 1);
    // Clear with concurrent overflow keeps ovf, clears unf; then clear alone.
    drive(0, 0, INC,  8'd0,   4'd1, 0, 1, "a_clrset",  8'd0,   1, 1, 0, 1);
    drive(0, 0, HOLD, 8'd0,   4'd0, 0, 1, "a_clr",     8'd0,   0, 0, 0, 1);
    // Zero step is a no-op even at the lower bound.
    drive(0, 0, INC,  8'd0,   4'd0, 0, 0, "a_inc_s0",  8'd0,   0, 0, 0, 1);
    drive(0, 0, DEC,  8'd0,   4'd0, 0, 0, "a_dec_s0",  8'd0,   0, 0, 0, 1);
    // Saturation re-pulses tc on every clipped update.
    drive(0, 0, LD,   8'd250, 4'd0, 1, 0, "a_ld250",   8'd250, 0, 0, 0, 1);
    drive(0, 0, INC,  8'd0,   4'd7, 1, 0, "a_sat_hi1", 8'd255, 1, 1, 0, 1);
    drive(0, 0, INC,  8'd0,   4'd7, 1, 0, "a_sat_hi2", 8'd255, 1, 1, 0, 1);
    drive(0, 0, LD,   8'd3,   4'd0, 1, 0, "a_ld3",     8'd3,   0, 1, 0, 1);
    drive(0, 0, DEC,  8'd0,   4'd5, 1, 0, "a_sat_lo1", 8'd0,   1, 1, 1, 1);
    drive(0, 0, DEC,  8'd0,   4'd5, 1, 0, "a_sat_lo2", 8'd0,   1, 1, 1, 1);
    drive(0, 0, HOLD, 8'd0,   4'd0, 0, 1, "a_clr2",    8'd0,   0, 0, 0, 1);
    drive(0, 0, LD,   8'd2,   4'd0, 0, 0, "a_ld2",     8'd2,   0, 0, 0, 1);
    drive(0, 0, DEC,  8'd0,   4'd5, 0, 0, "a_decwrp5", 8'd253, 1, 0, 1, 1);
    // Reset mid-count clears everything and discards the pending update.
    drive(0, 0, LD,   8'd97,  4'd0, 0, 0, "a_ld97",    8'd97,  0, 0, 1, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_inc98",   8'd98,  0, 0, 1, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_inc99",   8'd99,  0, 0, 1, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_inc100",  8'd100, 0, 0, 1, 1);
    drive(0, 1, INC,  8'd0,   4'd1, 0, 0, "a_rst_mid", 8'd0,   0, 0, 0, 0);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_rel",     8'd0,   0, 0, 0, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_resume1", 8'd1,   0, 0, 0, 1);
    drive(0, 0, INC,  8'd0,   4'd1, 0, 0, "a_resume2", 8'd2,   0, 0, 0, 1);

    // MAX_VAL 199: saturation, load clamp, and wrap at a non-power-of-two.
    drive(1, 1, HOLD, 8'd0,   4'd0, 0, 0, "b_reset",   8'd0,   0, 0, 0, 0);
    drive(1, 0, LD,   8'd195, 4'd0, 1, 0, "b_ld195",   8'd195, 0, 0, 0, 1);
    drive(1, 0, INC,  8'd0,   4'd7, 1, 0, "b_sat1",    8'd199, 1, 1, 0, 1);
    drive(1, 0, INC,  8'd0,   4'd7, 1, 0, "b_sat2",    8'd199, 1, 1, 0, 1);
    drive(1, 0, INC,  8'd0,   4'd7, 1, 0, "b_sat3",    8'd199, 1, 1, 0, 1);
    drive(1, 0, LD,   8'd250, 4'd0, 1, 0, "b_ldclamp", 8'd199, 1, 1, 0, 1);
    drive(1, 0, HOLD, 8'd0,   4'd0, 0, 1, "b_clr",     8'd199, 0, 0, 0, 1);
    drive(1, 0, LD,   8'd199, 4'd0, 0, 0, "b_ld199",   8'd199, 0, 0, 0, 1);
    drive(1, 0, INC,  8'd0,   4'd7, 0, 0, "b_incwrap", 8'd6,   1, 1, 0, 1);
    drive(1, 0, DEC,  8'd0,   4'd7, 0, 0, "b_decwrap", 8'd199, 1, 1, 1, 1);
    drive(1, 0, HOLD, 8'd0,   4'd7, 0, 0, "b_hold",    8'd199, 0, 1, 1, 1);

    // PRESCALE 4: after reset, tick_out is high after edges k with k%4==3,
    // so count updates land on edges 4, 8, 12, 16, ...
    drive(2, 1, HOLD, 8'd0,   4'd0, 0, 0, "c_reset",   8'd0,   0, 0, 0, 0);
    drive(2, 0, LD,   8'd10,  4'd0, 0, 0, "c_ld10",    8'd10,  0, 0, 0, 0);
    for (int k = 2; k <= 17; k++)
      drive(2, 0, INC, 8'd0, 4'd1, 0, 0, "c_inc", 8'(10 + k / 4), 0, 0, 0,
            (k % 4 == 3) ? 1 : 0);
    for (int k = 18; k <= 25; k++)
      drive(2, 0, HOLD, 8'd0, 4'd1, 0, 0, "c_hold", 8'd14, 0, 0, 0,
            (k % 4 == 3) ? 1 : 0);
    // DECREMENT between ticks has no effect until the tick edge.
    drive(2, 0, DEC,  8'd0,   4'd1, 0, 0, "c_dec_nt1", 8'd14,  0, 0, 0, 0);
    drive(2, 0, DEC,  8'd0,   4'd1, 0, 0, "c_dec_nt2", 8'd14,  0, 0, 0, 1);
    drive(2, 0, DEC,  8'd0,   4'd1, 0, 0, "c_dec_t",   8'd13,  0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
